// File: rtl/vluint7_enc.sv
// LEB128-style unsigned varint encoder: writes 7 payload bits per byte, LSB group first, into a byte memory.
// Latency: start edge k, N bytes committed at edges k+1..k+N, rd high from edge k+N.
// Backpressure: none; beg is a level request held until rd, and a new start needs beg to go low first.
//
// Ports:
//   clk, reset             single clock, asynchronous active-high reset
//   beg, value, addr       start request (level), value to encode, first byte address
//   mem_we/mem_addr/mem_data  one byte written per cycle while encoding
//   addr_out, rd, busy     address after the last byte, completion flag, encoding in progress

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

module vluint7_enc #(
    parameter int VAL_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       beg,
    input  logic [VAL_WIDTH-1:0]       value,
    input  logic [`MEM_ADDR_WIDTH-1:0] addr,
    output logic                       mem_we,
    output logic [`MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [`WORD_WIDTH-1:0]     mem_data,
    output logic [`MEM_ADDR_WIDTH-1:0] addr_out,
    output logic                       rd,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                       state;
    // The write port is registered, so the shift and address registers run
    // one byte ahead of it: while byte i is on mem_*, shift holds the groups
    // from i+1 upward and cur_addr holds the address of byte i+1.
    logic [VAL_WIDTH-1:0]         shift;
    logic [`MEM_ADDR_WIDTH-1:0]   cur_addr;

    logic [VAL_WIDTH-1:0]         value_rest;
    logic [VAL_WIDTH-1:0]         shift_rest;

    assign value_rest = value >> 7;
    assign shift_rest = shift >> 7;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            cur_addr <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            addr_out <= '0;
            rd       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beg) begin
                        state    <= WRITE;
                        mem_we   <= 1'b1;
                        busy     <= 1'b1;
                        mem_addr <= addr;
                        mem_data <= {|value_rest, value[6:0]};
                        shift    <= value_rest;
                        cur_addr <= addr + 1'b1;
                    end
                end
                WRITE: begin
                    // Bit 7 of the byte being written is the continuation flag.
                    if (mem_data[7]) begin
                        mem_addr <= cur_addr;
                        mem_data <= {|shift_rest, shift[6:0]};
                        shift    <= shift_rest;
                        cur_addr <= cur_addr + 1'b1;
                    end else begin
                        state    <= DONE;
                        mem_we   <= 1'b0;
                        busy     <= 1'b0;
                        mem_data <= '0;
                        rd       <= 1'b1;
                        // cur_addr already points one past the last byte (wraps silently).
                        addr_out <= cur_addr;
                    end
                end
                DONE: begin
                    if (!beg) begin
                        state <= IDLE;
                        rd    <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    rd     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vluint7_enc.sv
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 8
`endif

module tb_vluint7_enc;

    logic        clk;
    logic        reset;
    logic        beg;
    logic [31:0] value;
    logic [7:0]  addr;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  addr_out;
    logic        rd;
    logic        busy;

    int n_cmp;
    int n_bad;

    logic [7:0] log_addr[$];
    logic [7:0] log_data[$];

    vluint7_enc #(.VAL_WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .beg      (beg),
        .value    (value),
        .addr     (addr),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .addr_out (addr_out),
        .rd       (rd),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte committed to memory on every rising edge with mem_we high.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
    end

    // Start an encoding and wait for rd. Returns edges from start to rd and
    // the number of post-edge samples with busy high.
    task automatic do_encode(input logic [31:0] v, input logic [7:0] a,
                             output int rd_lat, output int busy_cyc);
        int n;
        log_addr.delete();
        log_data.delete();
        @(negedge clk);
        beg   = 1'b1;
        value = v;
        addr  = a;
        @(posedge clk);
        #1;
        busy_cyc = (busy === 1'b1) ? 1 : 0;
        @(negedge clk);
        // Inputs changing after the start edge must not disturb the encoding.
        value = 32'h1234_5678;
        addr  = 8'hAA;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1) busy_cyc++;
        end while (rd !== 1'b1 && n < 20);
        n_cmp++;
        if (rd !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_timeout: rd=%b after %0d edges, required 1", rd, n);
        end
        rd_lat = n;
    endtask

    task automatic release_beg();
        @(negedge clk);
        beg = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        beg   = 1'b0;
        value = '0;
        addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (mem_we !== 1'b0)   begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (rd !== 1'b0)       begin n_bad++; $display("FAIL reset_rd: got %b want 0", rd); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (mem_addr !== 8'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 00", mem_addr); end
        n_cmp++; if (mem_data !== 8'h0) begin n_bad++; $display("FAIL reset_mem_data: got %h want 00", mem_data); end
        n_cmp++; if (addr_out !== 8'h0) begin n_bad++; $display("FAIL reset_addr_out: got %h want 00", addr_out); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [7:0] ea[3];
        logic [7:0] ed[3];
        ea = '{8'd0, 8'd1, 8'd2};
        ed = '{8'hEE, 8'h96, 8'h01};
        do_encode(32'd19310, 8'd0, lat, bc);
        n_cmp++; if (log_addr.size() != 3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", log_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < log_addr.size()) begin
                n_cmp++;
                if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
                    n_bad++;
                    $display("FAIL basic_byte%0d: got %h@%0d want %h@%0d", i, log_data[i], log_addr[i], ed[i], ea[i]);
                end
            end
        end
        n_cmp++; if (addr_out !== 8'd3) begin n_bad++; $display("FAIL basic_addr_out: got %0d want 3", addr_out); end
        n_cmp++; if (lat != 3)          begin n_bad++; $display("FAIL basic_rd_latency: got %0d want 3", lat); end
        n_cmp++; if (bc != 3)           begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 3", bc); end
        release_beg();
    endtask

    task automatic test_small();
        int lat, bc;
        do_encode(32'd0, 8'd5, lat, bc);
        n_cmp++; if (log_addr.size() != 1) begin n_bad++; $display("FAIL zero_count: got %0d want 1", log_addr.size()); end
        if (log_addr.size() > 0) begin
            n_cmp++;
            if (log_addr[0] !== 8'd5 || log_data[0] !== 8'h00) begin
                n_bad++; $display("FAIL zero_byte: got %h@%0d want 00@5", log_data[0], log_addr[0]);
            end
        end
        n_cmp++; if (addr_out !== 8'd6) begin n_bad++; $display("FAIL zero_addr_out: got %0d want 6", addr_out); end
        n_cmp++; if (lat != 1)          begin n_bad++; $display("FAIL zero_rd_latency: got %0d want 1", lat); end
        release_beg();

        do_encode(32'd127, 8'd10, lat, bc);
        n_cmp++; if (log_addr.size() != 1) begin n_bad++; $display("FAIL v127_count: got %0d want 1", log_addr.size()); end
        if (log_addr.size() > 0) begin
            n_cmp++;
            if (log_addr[0] !== 8'd10 || log_data[0] !== 8'h7F) begin
                n_bad++; $display("FAIL v127_byte: got %h@%0d want 7f@10", log_data[0], log_addr[0]);
            end
        end
        release_beg();

        do_encode(32'd128, 8'd20, lat, bc);
        n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL v128_count: got %0d want 2", log_addr.size()); end
        if (log_addr.size() > 1) begin
            n_cmp++;
            if (log_addr[0] !== 8'd20 || log_data[0] !== 8'h80 || log_addr[1] !== 8'd21 || log_data[1] !== 8'h01) begin
                n_bad++; $display("FAIL v128_bytes: got %h@%0d %h@%0d want 80@20 01@21",
                                  log_data[0], log_addr[0], log_data[1], log_addr[1]);
            end
        end
        n_cmp++; if (addr_out !== 8'd22) begin n_bad++; $display("FAIL v128_addr_out: got %0d want 22", addr_out); end
        release_beg();
    endtask

    task automatic test_max();
        int lat, bc;
        logic [7:0] ed[5];
        ed = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        do_encode(32'hFFFF_FFFF, 8'd0, lat, bc);
        n_cmp++; if (log_addr.size() != 5) begin n_bad++; $display("FAIL max_count: got %0d want 5", log_addr.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < log_addr.size()) begin
                n_cmp++;
                if (log_addr[i] !== 8'(i) || log_data[i] !== ed[i]) begin
                    n_bad++;
                    $display("FAIL max_byte%0d: got %h@%0d want %h@%0d", i, log_data[i], log_addr[i], ed[i], i);
                end
            end
        end
        n_cmp++; if (addr_out !== 8'd5) begin n_bad++; $display("FAIL max_addr_out: got %0d want 5", addr_out); end
        n_cmp++; if (bc != 5)           begin n_bad++; $display("FAIL max_busy_cycles: got %0d want 5", bc); end
        n_cmp++; if (lat != 5)          begin n_bad++; $display("FAIL max_rd_latency: got %0d want 5", lat); end
        release_beg();
    endtask

    task automatic test_wrap();
        int lat, bc;
        do_encode(32'd300, 8'd255, lat, bc);
        n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", log_addr.size()); end
        if (log_addr.size() > 1) begin
            n_cmp++;
            if (log_addr[0] !== 8'd255 || log_data[0] !== 8'hAC || log_addr[1] !== 8'd0 || log_data[1] !== 8'h02) begin
                n_bad++; $display("FAIL wrap_bytes: got %h@%0d %h@%0d want ac@255 02@0",
                                  log_data[0], log_addr[0], log_data[1], log_addr[1]);
            end
        end
        n_cmp++; if (addr_out !== 8'd1) begin n_bad++; $display("FAIL wrap_addr_out: got %0d want 1", addr_out); end
        release_beg();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_encode(32'd19310, 8'd40, lat, bc);
        // Keep beg high for 10 cycles in total: DONE must hold, no restart.
        repeat (10 - lat) @(posedge clk);
        #1;
        n_cmp++; if (log_addr.size() != 3) begin n_bad++; $display("FAIL b2b_no_restart: got %0d writes want 3", log_addr.size()); end
        n_cmp++; if (rd !== 1'b1)          begin n_bad++; $display("FAIL b2b_rd_held: got %b want 1", rd); end
        n_cmp++; if (addr_out !== 8'd43)   begin n_bad++; $display("FAIL b2b_addr_out_held: got %0d want 43", addr_out); end
        @(negedge clk);
        beg  = 1'b0;
        addr = 8'd43;
        @(posedge clk);
        #1;
        n_cmp++; if (rd !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_drop: got %b want 0", rd); end
        do_encode(32'd300, 8'd43, lat, bc);
        n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL b2b2_count: got %0d want 2", log_addr.size()); end
        if (log_addr.size() > 1) begin
            n_cmp++;
            if (log_addr[0] !== 8'd43 || log_data[0] !== 8'hAC || log_addr[1] !== 8'd44 || log_data[1] !== 8'h02) begin
                n_bad++; $display("FAIL b2b2_bytes: got %h@%0d %h@%0d want ac@43 02@44",
                                  log_data[0], log_addr[0], log_data[1], log_addr[1]);
            end
        end
        n_cmp++; if (addr_out !== 8'd45) begin n_bad++; $display("FAIL b2b2_addr_out: got %0d want 45", addr_out); end
        release_beg();
    endtask

    task automatic test_beg_drop();
        int n;
        log_addr.delete();
        log_data.delete();
        @(negedge clk);
        beg   = 1'b1;
        value = 32'hFFFF_FFFF;
        addr  = 8'd60;
        @(posedge clk);
        @(negedge clk);
        beg = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (rd !== 1'b1 && n < 20);
        n_cmp++; if (rd !== 1'b1)          begin n_bad++; $display("FAIL drop_rd: got %b want 1", rd); end
        n_cmp++; if (log_addr.size() != 5) begin n_bad++; $display("FAIL drop_count: got %0d want 5", log_addr.size()); end
        n_cmp++; if (addr_out !== 8'd65)   begin n_bad++; $display("FAIL drop_addr_out: got %0d want 65", addr_out); end
        @(posedge clk);
        #1;
        n_cmp++; if (rd !== 1'b0)          begin n_bad++; $display("FAIL drop_return_idle: got rd=%b want 0", rd); end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        log_addr.delete();
        log_data.delete();
        @(negedge clk);
        beg   = 1'b1;
        value = 32'hFFFF_FFFF;
        addr  = 8'd0;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL abort_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (rd !== 1'b0)     begin n_bad++; $display("FAIL abort_rd: got %b want 0", rd); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        beg = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL abort_writes: got %0d want 2", log_addr.size()); end
        do_encode(32'd300, 8'd100, lat, bc);
        n_cmp++; if (log_addr.size() != 2) begin n_bad++; $display("FAIL post_reset_count: got %0d want 2", log_addr.size()); end
        if (log_addr.size() > 1) begin
            n_cmp++;
            if (log_addr[0] !== 8'd100 || log_data[0] !== 8'hAC || log_addr[1] !== 8'd101 || log_data[1] !== 8'h02) begin
                n_bad++; $display("FAIL post_reset_bytes: got %h@%0d %h@%0d want ac@100 02@101",
                                  log_data[0], log_addr[0], log_data[1], log_addr[1]);
            end
        end
        n_cmp++; if (addr_out !== 8'd102) begin n_bad++; $display("FAIL post_reset_addr_out: got %0d want 102", addr_out); end
        release_beg();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_small();
        test_max();
        test_wrap();
        test_back_to_back();
        test_beg_drop();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vluint7_enc.md
VLUINT7_ENC -- requirements
Module: vluint7_enc

Interface
REQ-001 Parameter: VAL_WIDTH, default 32, width of the unsigned value to encode.
REQ-002 Widths `MEM_ADDR_WIDTH and `WORD_WIDTH come from common.h; `WORD_WIDTH SHALL be 8.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 beg  in  1  start request, level-sensitive, held by the requester until rd is seen.
REQ-006 value  in  VAL_WIDTH  unsigned integer to encode, sampled on the start edge.
REQ-007 addr  in  `MEM_ADDR_WIDTH  address of the first encoded byte, sampled on the start edge.
REQ-008 mem_we  out  1  memory write strobe.
REQ-009 mem_addr  out  `MEM_ADDR_WIDTH  memory write address.
REQ-010 mem_data  out  `WORD_WIDTH  memory write data.
REQ-011 addr_out  out  `MEM_ADDR_WIDTH  address immediately after the last written byte.
REQ-012 rd  out  1  encoding complete, addr_out valid.
REQ-013 busy  out  1  encoding in progress.

Function
REQ-014 The encoding SHALL be LEB128-style: 7 payload bits per byte, least-significant group first, bit 7 = 1 on every byte except the last, where bit 7 = 0.
REQ-015 The byte count SHALL be the minimum needed: 1 byte for value < 128; at most ceil(VAL_WIDTH/7) bytes (5 for VAL_WIDTH = 32).
REQ-016 The FSM SHALL have three states: IDLE, WRITE, DONE.
REQ-017 IDLE -> WRITE on the rising edge where beg = 1. On that edge, value is loaded into a shift register and addr into the current-address register.
REQ-018 In WRITE, each cycle SHALL drive the following, one byte per cycle:
- mem_we = 1
- mem_addr = current address
- mem_data = {more, shift[6:0]}, where more = (shift >> 7) != 0
REQ-019 Each WRITE edge SHALL shift right by 7 and increment the current address modulo 2^`MEM_ADDR_WIDTH.
REQ-020 On the WRITE edge where more = 0, the FSM SHALL go to DONE, with addr_out = last written address + 1 (modulo).
REQ-021 Latency: for start edge k and N bytes, the bytes SHALL be committed at edges k+1..k+N, and rd SHALL be high from edge k+N.
REQ-022 busy = 1 exactly in WRITE. mem_we = 0 outside WRITE.
REQ-023 In DONE, rd = 1 and addr_out is held. DONE -> IDLE on the first edge where beg = 0. No restart is possible without beg first going low.
REQ-024 beg going low during WRITE SHALL be ignored. The encoding completes, DONE lasts at least one cycle, then the FSM returns to IDLE.
REQ-025 value and addr changes after the start edge SHALL NOT affect the encoding in progress.
REQ-026 Address wrap-around past 2^`MEM_ADDR_WIDTH-1 to 0 SHALL be silent, for both mem_addr and addr_out.

Reset
REQ-027 While reset = 1, asynchronously:
- state = IDLE
- mem_we = 0, rd = 0, busy = 0
- mem_addr = 0, mem_data = 0, addr_out = 0
- shift and address registers cleared
REQ-028 A reset during WRITE SHALL abort immediately with no further writes; bytes already committed remain in memory.
REQ-029 After reset deasserts, a start SHALL require beg = 1 sampled in IDLE, including when beg is already high.

Verification
REQ-030 value = 19310, addr = 0, beg held -> 0xEE@0, 0x96@1, 0x01@2 on three consecutive edges; addr_out = 3; rd at start+3.
REQ-031 value = 0, addr = 5 -> single write 0x00@5; addr_out = 6; rd at start+1. value = 127 -> 0x7F; value = 128 -> 0x80, 0x01.
REQ-032 value = 0xFFFFFFFF, addr = 0 -> 0xFF, 0xFF, 0xFF, 0xFF, 0x0F at 0..4; addr_out = 5; busy high for exactly 5 cycles.
REQ-033 value = 300, addr = 2^`MEM_ADDR_WIDTH-1 -> 0xAC at the top address, 0x02@0; addr_out = 1.
REQ-034 Back-to-back chaining: beg held 10 cycles, dropped with addr <= addr_out, raised again with value = 300 -> second encoding starts at the previous addr_out; rd drops one edge after beg = 0.
REQ-035 Reset asserted mid-encoding of 0xFFFFFFFF after 2 bytes -> mem_we, rd, busy = 0 immediately; no writes to address 2 or later; a fresh start afterwards encodes correctly.
